// File: rtl/board_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : board_pkg
//  Description : Board-level constants shared by the switch conditioning
//                path (switch count and debounce interval choices).
//  Revision    : 1.0  initial release
// ============================================================================
package board_pkg;

    // Number of slide switches on the board.
    localparam int SW_WIDTH       = 8;

    // Debounce interval in clock cycles: short value for simulation,
    // long value (roughly 5 ms at 100 MHz) for hardware builds.
    localparam int DEBOUNCE_SIM   = 16;
    localparam int DEBOUNCE_BOARD = 500000;

endpackage : board_pkg
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : Single-bit switch conditioner: two-flop synchronizer,
//                stability counter and one-cycle rise/fall pulses.
//  Ports       : clk       - system clock
//                rst       - synchronous active-high reset
//                i_sw      - raw asynchronous switch level
//                o_sw      - debounced level (registered)
//                o_rise    - one-cycle pulse on debounced 0->1
//                o_fall    - one-cycle pulse on debounced 1->0
//                o_update  - high in the cycle before o_sw changes; driven
//                            only from registers, used by the parent to
//                            register an aggregate change pulse
//  Revision    : 1.0  initial release
// ============================================================================
module debounce_bit #(
    parameter int STABLE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sw,
    output logic o_sw,
    output logic o_rise,
    output logic o_fall,
    output logic o_update
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

    // Count value at which the next differing cycle commits the new level.
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_out;
    logic             r_rise;
    logic             r_fall;
    logic [CNT_W-1:0] r_cnt;

    logic             w_differ;
    logic             w_take;

    assign w_differ = r_s2 ^ r_out;
    assign w_take   = w_differ && (r_cnt == c_CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_out  <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_sw;
            r_s2   <= r_s1;
            // Pulses are rewritten every edge, so they last exactly one cycle.
            r_rise <= w_take &  r_s2;
            r_fall <= w_take & ~r_s2;
            if (w_take) begin
                r_out <= r_s2;
                r_cnt <= '0;
            end else if (w_differ) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                // Any return to the committed level restarts the full count.
                r_cnt <= '0;
            end
        end
    end

    assign o_sw     = r_out;
    assign o_rise   = r_rise;
    assign o_fall   = r_fall;
    assign o_update = w_take;

endmodule : debounce_bit
`default_nettype wire

// File: rtl/sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : sw_debounce
//  Description : Multi-bit slide switch debouncer feeding the priority
//                encoder / seven-segment stage. Each bit is conditioned
//                independently; an aggregate change pulse is also produced.
//  Ports       : clk      - system clock
//                rst      - synchronous active-high reset
//                sw_in    - raw asynchronous switch levels [WIDTH]
//                sw_out   - debounced switch levels, registered [WIDTH]
//                rise     - per-bit one-cycle 0->1 pulse [WIDTH]
//                fall     - per-bit one-cycle 1->0 pulse [WIDTH]
//                changed  - one-cycle pulse, equal to |(rise|fall)
//  Revision    : 1.0  initial release
// ============================================================================
module sw_debounce
    import board_pkg::*;
#(
    parameter int WIDTH         = SW_WIDTH,
    parameter int STABLE_CYCLES = DEBOUNCE_SIM
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] w_update;
    logic             r_changed;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES (STABLE_CYCLES)
        ) u_bit (
            .clk      (clk),
            .rst      (rst),
            .i_sw     (sw_in[gi]),
            .o_sw     (sw_out[gi]),
            .o_rise   (rise[gi]),
            .o_fall   (fall[gi]),
            .o_update (w_update[gi])
        );
    end

    // Registered on the same edge as the per-bit pulses, so it always
    // coincides with |(rise|fall) without a combinational OR on outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= |w_update;
        end
    end

    assign changed = r_changed;

endmodule : sw_debounce
`default_nettype wire

// File: tb/tb_sw_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sw_debounce
//  Description : Self-checking bench for sw_debounce. A table of
//                {rst, sw_in, repeat, expected outputs} rows drives a
//                STABLE_CYCLES=4 instance; a short hand sequence drives a
//                STABLE_CYCLES=1 instance. Expected values go through a
//                scoreboard queue and are compared one cycle later.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sw_debounce;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    logic [W-1:0] sw_in1;
    logic [W-1:0] sw_out1;
    logic [W-1:0] rise1;
    logic [W-1:0] fall1;
    logic         changed1;

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in),
        .sw_out  (sw_out),
        .rise    (rise),
        .fall    (fall),
        .changed (changed)
    );

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(1)) dut1 (
        .clk     (clk),
        .rst     (rst),
        .sw_in   (sw_in1),
        .sw_out  (sw_out1),
        .rise    (rise1),
        .fall    (fall1),
        .changed (changed1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic [W-1:0] sw;
        int           n;
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } row_t;

    typedef struct {
        string        name;
        logic [W-1:0] out;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         chg;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];
    int   vectors;
    int   miscompares;

    function automatic void add(input logic r, input logic [W-1:0] sw, input int n,
                                input logic [W-1:0] o, input logic [W-1:0] ri,
                                input logic [W-1:0] fa, input logic ch);
        row_t t;
        t.rst = r; t.sw = sw; t.n = n; t.out = o; t.rise = ri; t.fall = fa; t.chg = ch;
        rows.push_back(t);
    endfunction

    task automatic compare(input logic [W-1:0] o, input logic [W-1:0] ri,
                           input logic [W-1:0] fa, input logic ch);
        exp_t e;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard: empty queue, got out=%h rise=%h fall=%h chg=%b", o, ri, fa, ch);
        end else begin
            e = sb.pop_front();
            vectors++;
            if (o !== e.out || ri !== e.rise || fa !== e.fall || ch !== e.chg) begin
                miscompares++;
                $display("FAIL %s: got out=%h rise=%h fall=%h chg=%b, want out=%h rise=%h fall=%h chg=%b",
                         e.name, o, ri, fa, ch, e.out, e.rise, e.fall, e.chg);
            end
        end
    endtask

    // Watchdog: the bench is edge-driven only, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t e;
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        sw_in       = '0;
        sw_in1      = '0;

        // Reset with inputs held high, then release: change at edge 1+4+1.
        add(1, 8'hFF, 3, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'hFF, 5, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'hFF, 1, 8'hFF, 8'hFF, 8'h00, 1);
        add(0, 8'hFF, 2, 8'hFF, 8'h00, 8'h00, 0);
        // All bits back low.
        add(0, 8'h00, 5, 8'hFF, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 8'h00, 8'h00, 8'hFF, 1);
        add(0, 8'h00, 2, 8'h00, 8'h00, 8'h00, 0);
        // Clean step on bit 7 and back.
        add(0, 8'h80, 5, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h80, 1, 8'h80, 8'h80, 8'h00, 1);
        add(0, 8'h80, 2, 8'h80, 8'h00, 8'h00, 0);
        add(0, 8'h00, 5, 8'h80, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 8'h00, 8'h00, 8'h80, 1);
        add(0, 8'h00, 2, 8'h00, 8'h00, 8'h00, 0);
        // Three-cycle glitch on bit 3: one short of the count, rejected.
        add(0, 8'h08, 3, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h00, 6, 8'h00, 8'h00, 8'h00, 0);
        // Bounce 1,1,0,1,0 then stable 1 from edge j: rise at j+5 only.
        add(0, 8'h08, 2, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h08, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h08, 5, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h08, 1, 8'h08, 8'h08, 8'h00, 1);
        add(0, 8'h08, 2, 8'h08, 8'h00, 8'h00, 0);
        // 08 -> 02: simultaneous fall and rise on different bits.
        add(0, 8'h02, 5, 8'h08, 8'h00, 8'h00, 0);
        add(0, 8'h02, 1, 8'h02, 8'h02, 8'h08, 1);
        add(0, 8'h02, 2, 8'h02, 8'h00, 8'h00, 0);
        // 02 -> 01.
        add(0, 8'h01, 5, 8'h02, 8'h00, 8'h00, 0);
        add(0, 8'h01, 1, 8'h01, 8'h01, 8'h02, 1);
        add(0, 8'h01, 2, 8'h01, 8'h00, 8'h00, 0);
        add(0, 8'h00, 5, 8'h01, 8'h00, 8'h00, 0);
        add(0, 8'h00, 1, 8'h00, 8'h00, 8'h01, 1);
        add(0, 8'h00, 2, 8'h00, 8'h00, 8'h00, 0);
        // Reset mid-count: s2 differs after edge k+1, reset at edge k+3;
        // first non-reset edge k+4, change at k+9.
        add(0, 8'h01, 3, 8'h00, 8'h00, 8'h00, 0);
        add(1, 8'h01, 1, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h01, 5, 8'h00, 8'h00, 8'h00, 0);
        add(0, 8'h01, 1, 8'h01, 8'h01, 8'h00, 1);
        add(0, 8'h01, 2, 8'h01, 8'h00, 8'h00, 0);

        for (int i = 0; i < rows.size(); i++) begin
            for (int c = 0; c < rows[i].n; c++) begin
                @(negedge clk);
                rst   = rows[i].rst;
                sw_in = rows[i].sw;
                e.name = $sformatf("row%0d.%0d", i, c);
                e.out = rows[i].out; e.rise = rows[i].rise;
                e.fall = rows[i].fall; e.chg = rows[i].chg;
                sb.push_back(e);
                @(posedge clk);
                #1;
                compare(sw_out, rise, fall, changed);
            end
        end

        // STABLE_CYCLES=1: change two edges after the input, and a single
        // cycle difference at s2 is already enough to commit.
        begin
            logic [W-1:0] s_sw  [7] = '{8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A, 8'h5A, 8'h5A};
            logic [W-1:0] s_out [7] = '{8'h00, 8'h00, 8'h5A, 8'h5A, 8'h5A, 8'h5B, 8'h5A};
            logic [W-1:0] s_ri  [7] = '{8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h01, 8'h00};
            logic [W-1:0] s_fa  [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
            logic         s_ch  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
            @(negedge clk);
            rst    = 1'b1;
            sw_in  = '0;
            sw_in1 = '0;
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 7; c++) begin
                sw_in1 = s_sw[c];
                e.name = $sformatf("stable1.%0d", c);
                e.out = s_out[c]; e.rise = s_ri[c]; e.fall = s_fa[c]; e.chg = s_ch[c];
                sb.push_back(e);
                @(posedge clk);
                #1;
                compare(sw_out1, rise1, fall1, changed1);
                @(negedge clk);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sw_debounce
`default_nettype wire

// File: doc/sw_debounce.md
Name: sw_debounce

Overview:
- Conditions raw board slide switches before they reach the 8-input priority encoder / seven-segment stage.
- Per bit: two-flop synchronizer, then a stability counter. The debounced level updates only after the synchronized input has differed from it for STABLE_CYCLES consecutive cycles.
- Also produces one-cycle rise/fall pulses and an aggregate change pulse for downstream display or logging logic.

Parameters:
- WIDTH, 8: number of switch bits handled.
- STABLE_CYCLES, 16: consecutive differing cycles required before an output bit changes. Legal range ≥ 1; board builds override to 500000.
- CNT_W, $clog2(STABLE_CYCLES+1): localparam, per-bit counter width. Not user-settable.

Ports:
- clk  in  1  single system clock
- rst  in  1  synchronous, active-high reset
- sw_in  in  WIDTH  raw asynchronous switch levels
- sw_out  out  WIDTH  debounced switch levels, registered
- rise  out  WIDTH  one-cycle pulse per bit on a debounced 0->1 change
- fall  out  WIDTH  one-cycle pulse per bit on a debounced 1->0 change
- changed  out  1  one-cycle pulse, equal to |(rise|fall)

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state changes only on the rising edge of clk.
- Reset (rst=1 at an edge): s1, s2, sw_out, all counters, rise, fall and changed go to 0. This holds regardless of sw_in.
- Synchronizer: s1 <= sw_in; s2 <= s1. Only s2 feeds the counter logic.
- Per bit i, each non-reset edge:
  - If s2[i] == sw_out[i]: cnt[i] <= 0; no pulse.
  - Else if cnt[i] == STABLE_CYCLES-1: sw_out[i] <= s2[i]; cnt[i] <= 0; rise[i] <= s2[i]; fall[i] <= ~s2[i].
  - Else: cnt[i] <= cnt[i]+1; no pulse.
- rise and fall are 0 on every edge where the update branch is not taken, so each pulse lasts exactly one cycle.
- changed is registered on the same edge as rise/fall. It is never derived combinationally from outputs.
- Latency: if sw_in is stable from before edge k, sw_out changes at edge k+STABLE_CYCLES+1 and the pulses are high for the following cycle. With STABLE_CYCLES=1, the change is at edge k+2.
- Glitch rejection: any return of s2[i] to sw_out[i] before the count completes clears cnt[i]. The full STABLE_CYCLES count restarts on the next difference.
- Bits are fully independent. Simultaneous updates on multiple bits occur on the same edge, each with its own pulse.
- Counter never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- Reset mid-count: the count is discarded. After release, a held-high input again needs the full STABLE_CYCLES+1 edge latency, counted from the first non-reset edge.
- No combinational path from sw_in to any output.

Decomposition:
- Shared package (board_pkg): SW_WIDTH=8 and DEBOUNCE_SIM=16 / DEBOUNCE_BOARD=500000 constants. No typedefs needed.
- One sub-module, debounce_bit: synchronizer + counter + pulse regs for a single bit, parameterized by STABLE_CYCLES.
- sw_debounce instantiates WIDTH copies in a generate loop and ORs the pulses into changed.

Test Plan:
- Reset with sw_in=8'hFF held, STABLE_CYCLES=4, rst dropped so edge 1 is the first non-reset edge -> sw_out=8'h00 through edge 5; sw_out=8'hFF at edge 6 (edge 1 + 4 + 1); rise=8'hFF and changed=1 for exactly one cycle.
- Clean step, STABLE_CYCLES=4: sw_in[7] 0->1 before edge k, others 0 -> sw_out=8'h80 at edge k+5; rise=8'h80 one cycle; fall=0.
- Short glitch: sw_in[3] high for 3 cycles then low, STABLE_CYCLES=4 -> sw_out stays 8'h00; rise, fall and changed never assert.
- Bounce: sw_in[3] pattern 1,1,0,1,0,1 then stable 1 from edge j -> sw_out[3] rises only at edge j+5; exactly one rise pulse.
- Simultaneous: sw_out=8'h02, sw_in changes to 8'h01 before edge k -> at edge k+5 sw_out=8'h01, rise=8'h01, fall=8'h02, changed=1 for one cycle.
- Reset mid-count: sw_in[0]=1 and rst asserted 2 cycles after the difference reaches s2, held 1 cycle -> sw_out=0; after release, sw_out[0]=1 exactly 5 edges after the first non-reset edge.
